// File: rtl/mem_pkg.sv
// Shared definitions for the memory (M) pipeline stage: funct3 width codes,
// AMO operation codes, the canonical NOP encoding and the write FSM states.
package mem_pkg;

   // Canonical bubble instruction (add x0, x0, x0)
   localparam logic [31:0] NOP_INSTR = 32'h0000_0033;

   // Load width codes (funct3)
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Store width codes (funct3)
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // AMO operation codes found in funct7[6:2]
   localparam logic [4:0] AMO_ADD  = 5'h00;
   localparam logic [4:0] AMO_SWAP = 5'h01;
   localparam logic [4:0] AMO_LR   = 5'h02;
   localparam logic [4:0] AMO_SC   = 5'h03;

   // Data-memory write port handshake state
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } wr_state_e;

   // Word-aligned version of a byte address
   function automatic logic [31:0] word_addr(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

   // Read-modify-write AMOs (everything except LR/SC) always write the new value
   function automatic logic amo_is_rmw(input logic [4:0] op);
      return (op != AMO_LR) && (op != AMO_SC);
   endfunction

endpackage

// File: rtl/memory_unit_align.sv
// Combinational byte-lane logic: positions store data and byte enables,
// extracts and extends load data, and detects misaligned accesses.
module load_store_align
   import mem_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  offset_i,
   input  logic        is_amo_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] mdata_i,
   output logic [31:0] load_data_o,
   output logic [31:0] store_data_o,
   output logic [3:0]  store_mask_o,
   output logic        misalign_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte/half out of the memory word and extend it
   always_comb begin
      byte_sel    = mdata_i[{offset_i, 3'b000} +: 8];
      half_sel    = offset_i[1] ? mdata_i[31:16] : mdata_i[15:0];
      load_data_o = mdata_i;
      case (funct3_i)
         F3_LB:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   load_data_o = {{16{half_sel[15]}}, half_sel};
         F3_LW:   load_data_o = mdata_i;
         F3_LBU:  load_data_o = {24'd0, byte_sel};
         F3_LHU:  load_data_o = {16'd0, half_sel};
         default: load_data_o = mdata_i;
      endcase
   end

   // Replicate store data across lanes and enable only the addressed bytes
   always_comb begin
      store_mask_o = 4'b1111;
      store_data_o = store_data_i;
      case (funct3_i)
         F3_SB: begin
            store_mask_o = 4'b0001 << offset_i;
            store_data_o = {4{store_data_i[7:0]}};
         end
         F3_SH: begin
            store_mask_o = offset_i[1] ? 4'b1100 : 4'b0011;
            store_data_o = {2{store_data_i[15:0]}};
         end
         F3_SW: begin
            store_mask_o = 4'b1111;
            store_data_o = store_data_i;
         end
         default: begin
            store_mask_o = 4'b1111;
            store_data_o = store_data_i;
         end
      endcase
   end

   // Halfwords need even addresses; words and AMOs need word alignment
   always_comb begin
      misalign_o = 1'b0;
      if (is_amo_i) begin
         misalign_o = (offset_i != 2'b00);
      end else if (funct3_i[1:0] == 2'b01) begin
         misalign_o = offset_i[0];
      end else if (funct3_i[1:0] == 2'b10) begin
         misalign_o = (offset_i != 2'b00);
      end
   end

endmodule

// File: rtl/memory_unit.sv
// Pipeline M stage: load formatting, store/AMO/SC writes over a valid/ready
// port, LR/SC reservation, CSR write strobe and the MW writeback bank.
module memory_unit
   import mem_pkg::*;
#(
   parameter bit LRSC_EN        = 1'b1,
   parameter bit MISALIGN_CHECK = 1'b1
)(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        W_flush_i,
   output logic        M_stall_o,
   input  logic [31:0] EM_PC_i,
   input  logic [31:0] EM_instr_i,
   input  logic        EM_nop_i,
   input  logic        EM_isLoad_i,
   input  logic        EM_isStore_i,
   input  logic        EM_isCSR_i,
   input  logic        EM_isAMO_i,
   input  logic        EM_wbEnable_i,
   input  logic [5:0]  EM_rdId_i,
   input  logic [5:0]  EM_rs1Id_i,
   input  logic [11:0] EM_csrId_i,
   input  logic [2:0]  EM_funct3_i,
   input  logic [6:0]  EM_funct7_i,
   input  logic [31:0] EM_rs2_i,
   input  logic [31:0] EM_Eresult_i,
   input  logic [31:0] EM_addr_i,
   input  logic [31:0] EM_Mdata_i,
   input  logic [31:0] EM_CSRdata_i,
   output logic        DMemWValid_o,
   input  logic        DMemWReady_i,
   output logic [31:0] DMemWAddr_o,
   output logic [31:0] DMemWData_o,
   output logic [3:0]  DMemWMask_o,
   output logic        csrWEnable_o,
   output logic [11:0] csrWAddr_o,
   output logic [31:0] csrWData_o,
   output logic [31:0] MW_PC_o,
   output logic [31:0] MW_instr_o,
   output logic        MW_nop_o,
   output logic [5:0]  MW_rdId_o,
   output logic [31:0] MW_wbData_o,
   output logic        MW_wbEnable_o,
   output logic        MW_misalign_o
);

   logic        unused_funct7_low;

   logic [31:0] load_data;
   logic [31:0] st_data;
   logic [3:0]  st_mask;
   logic        raw_misalign;

   logic [4:0]  amo_op;
   logic        active;
   logic        is_lr;
   logic        is_sc;
   logic        misalign;
   logic        res_hit;
   logic        sc_ok;
   logic        need_write;
   logic [31:0] wr_data_now;
   logic [3:0]  wr_mask_now;
   logic [31:0] wb_data;

   logic        w_valid;
   logic        stall;
   logic        csr_fire;

   wr_state_e   state_q, state_d;
   logic [31:0] wr_addr_q, wr_addr_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic [3:0]  wr_mask_q, wr_mask_d;
   logic        res_valid_q, res_valid_d;
   logic [29:0] res_addr_q, res_addr_d;

   logic [31:0] mw_pc_q, mw_pc_d;
   logic [31:0] mw_instr_q, mw_instr_d;
   logic        mw_nop_q, mw_nop_d;
   logic [5:0]  mw_rd_q, mw_rd_d;
   logic [31:0] mw_wb_data_q, mw_wb_data_d;
   logic        mw_wb_en_q, mw_wb_en_d;
   logic        mw_misalign_q, mw_misalign_d;

   assign unused_funct7_low = ^EM_funct7_i[1:0];

   load_store_align u_align (
      .funct3_i     (EM_funct3_i),
      .offset_i     (EM_addr_i[1:0]),
      .is_amo_i     (EM_isAMO_i),
      .store_data_i (EM_rs2_i),
      .mdata_i      (EM_Mdata_i),
      .load_data_o  (load_data),
      .store_data_o (st_data),
      .store_mask_o (st_mask),
      .misalign_o   (raw_misalign)
   );

   // Decode the instruction in M: misalignment, SC outcome, whether a write is needed
   always_comb begin
      amo_op     = EM_funct7_i[6:2];
      active     = !EM_nop_i;
      is_lr      = active && EM_isAMO_i && (amo_op == AMO_LR);
      is_sc      = active && EM_isAMO_i && (amo_op == AMO_SC);
      misalign   = MISALIGN_CHECK && active &&
                   (EM_isLoad_i || EM_isStore_i || EM_isAMO_i) && raw_misalign;
      res_hit    = LRSC_EN && res_valid_q && (res_addr_q == EM_addr_i[31:2]);
      sc_ok      = is_sc && res_hit && !misalign;
      need_write = active && !misalign &&
                   (EM_isStore_i || (EM_isAMO_i && amo_is_rmw(amo_op)) || sc_ok);
      wr_data_now = st_data;
      wr_mask_now = st_mask;
      if (EM_isAMO_i) begin
         wr_mask_now = 4'b1111;
         wr_data_now = (amo_op == AMO_SC) ? EM_rs2_i : EM_Eresult_i;
      end
   end

   // Write handshake FSM: issue in IDLE, hold registered copies while waiting
   always_comb begin
      state_d     = state_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      wr_mask_d   = wr_mask_q;
      w_valid     = 1'b0;
      stall       = 1'b0;
      DMemWAddr_o = word_addr(EM_addr_i);
      DMemWData_o = wr_data_now;
      DMemWMask_o = wr_mask_now;
      case (state_q)
         ST_IDLE: begin
            if (need_write) begin
               w_valid = 1'b1;
               if (!DMemWReady_i) begin
                  stall     = 1'b1;
                  state_d   = ST_WAIT;
                  wr_addr_d = word_addr(EM_addr_i);
                  wr_data_d = wr_data_now;
                  wr_mask_d = wr_mask_now;
               end
            end
         end
         ST_WAIT: begin
            w_valid     = 1'b1;
            DMemWAddr_o = wr_addr_q;
            DMemWData_o = wr_data_q;
            DMemWMask_o = wr_mask_q;
            if (DMemWReady_i) begin
               state_d = ST_IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign DMemWValid_o = reset_i && w_valid;
   assign M_stall_o    = reset_i && stall;

   // Reservation tracking: LR sets it, SC or a write to the reserved word clears it
   always_comb begin
      res_valid_d = res_valid_q;
      res_addr_d  = res_addr_q;
      if (!stall && active && !misalign) begin
         if (is_lr) begin
            res_valid_d = LRSC_EN;
            res_addr_d  = EM_addr_i[31:2];
         end else if (is_sc) begin
            res_valid_d = 1'b0;
         end else if (need_write && res_hit) begin
            res_valid_d = 1'b0;
         end
      end
   end

   // CSR strobe fires once, when the instruction is actually retiring
   always_comb begin
      csr_fire     = active && EM_isCSR_i && !stall &&
                     !(EM_funct3_i[1] && (EM_rs1Id_i == 6'd0));
      csrWEnable_o = reset_i && csr_fire;
      csrWAddr_o   = EM_csrId_i;
      csrWData_o   = EM_Eresult_i;
   end

   // Writeback value selection: load, CSR, AMO/SC, then ALU result
   always_comb begin
      wb_data = EM_Eresult_i;
      if (EM_isLoad_i) begin
         wb_data = load_data;
      end else if (EM_isCSR_i) begin
         wb_data = EM_CSRdata_i;
      end else if (EM_isAMO_i) begin
         wb_data = (amo_op == AMO_SC) ? {31'd0, !sc_ok} : EM_Mdata_i;
      end
   end

   // MW bank takes the current instruction only when not stalled or flushed
   always_comb begin
      mw_pc_d       = 32'd0;
      mw_instr_d    = NOP_INSTR;
      mw_nop_d      = 1'b1;
      mw_rd_d       = 6'd0;
      mw_wb_data_d  = 32'd0;
      mw_wb_en_d    = 1'b0;
      mw_misalign_d = 1'b0;
      if (!W_flush_i && !stall) begin
         mw_pc_d       = EM_PC_i;
         mw_instr_d    = EM_instr_i;
         mw_nop_d      = EM_nop_i;
         mw_rd_d       = EM_rdId_i;
         mw_wb_data_d  = wb_data;
         mw_wb_en_d    = EM_wbEnable_i && active && !misalign;
         mw_misalign_d = misalign;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q       <= ST_IDLE;
         wr_addr_q     <= 32'd0;
         wr_data_q     <= 32'd0;
         wr_mask_q     <= 4'd0;
         res_valid_q   <= 1'b0;
         res_addr_q    <= 30'd0;
         mw_pc_q       <= 32'd0;
         mw_instr_q    <= NOP_INSTR;
         mw_nop_q      <= 1'b1;
         mw_rd_q       <= 6'd0;
         mw_wb_data_q  <= 32'd0;
         mw_wb_en_q    <= 1'b0;
         mw_misalign_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         wr_mask_q     <= wr_mask_d;
         res_valid_q   <= res_valid_d;
         res_addr_q    <= res_addr_d;
         mw_pc_q       <= mw_pc_d;
         mw_instr_q    <= mw_instr_d;
         mw_nop_q      <= mw_nop_d;
         mw_rd_q       <= mw_rd_d;
         mw_wb_data_q  <= mw_wb_data_d;
         mw_wb_en_q    <= mw_wb_en_d;
         mw_misalign_q <= mw_misalign_d;
      end
   end

   assign MW_PC_o       = mw_pc_q;
   assign MW_instr_o    = mw_instr_q;
   assign MW_nop_o      = mw_nop_q;
   assign MW_rdId_o     = mw_rd_q;
   assign MW_wbData_o   = mw_wb_data_q;
   assign MW_wbEnable_o = mw_wb_en_q;
   assign MW_misalign_o = mw_misalign_q;

endmodule

// File: tb/tb_memory_unit.sv
// Directed self-checking bench for the memory_unit M stage.
module tb_memory_unit;
   import mem_pkg::*;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        W_flush_i;
   logic        M_stall_o;
   logic [31:0] EM_PC_i, EM_instr_i;
   logic        EM_nop_i, EM_isLoad_i, EM_isStore_i, EM_isCSR_i, EM_isAMO_i, EM_wbEnable_i;
   logic [5:0]  EM_rdId_i, EM_rs1Id_i;
   logic [11:0] EM_csrId_i;
   logic [2:0]  EM_funct3_i;
   logic [6:0]  EM_funct7_i;
   logic [31:0] EM_rs2_i, EM_Eresult_i, EM_addr_i, EM_Mdata_i, EM_CSRdata_i;
   logic        DMemWValid_o, DMemWReady_i;
   logic [31:0] DMemWAddr_o, DMemWData_o;
   logic [3:0]  DMemWMask_o;
   logic        csrWEnable_o;
   logic [11:0] csrWAddr_o;
   logic [31:0] csrWData_o;
   logic [31:0] MW_PC_o, MW_instr_o;
   logic        MW_nop_o;
   logic [5:0]  MW_rdId_o;
   logic [31:0] MW_wbData_o;
   logic        MW_wbEnable_o, MW_misalign_o;

   int checks = 0;
   int passes = 0;

   always #5 clk_i = ~clk_i;

   memory_unit #(.LRSC_EN(1'b1), .MISALIGN_CHECK(1'b1)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .W_flush_i(W_flush_i), .M_stall_o(M_stall_o),
      .EM_PC_i(EM_PC_i), .EM_instr_i(EM_instr_i), .EM_nop_i(EM_nop_i),
      .EM_isLoad_i(EM_isLoad_i), .EM_isStore_i(EM_isStore_i), .EM_isCSR_i(EM_isCSR_i),
      .EM_isAMO_i(EM_isAMO_i), .EM_wbEnable_i(EM_wbEnable_i), .EM_rdId_i(EM_rdId_i),
      .EM_rs1Id_i(EM_rs1Id_i), .EM_csrId_i(EM_csrId_i), .EM_funct3_i(EM_funct3_i),
      .EM_funct7_i(EM_funct7_i), .EM_rs2_i(EM_rs2_i), .EM_Eresult_i(EM_Eresult_i),
      .EM_addr_i(EM_addr_i), .EM_Mdata_i(EM_Mdata_i), .EM_CSRdata_i(EM_CSRdata_i),
      .DMemWValid_o(DMemWValid_o), .DMemWReady_i(DMemWReady_i), .DMemWAddr_o(DMemWAddr_o),
      .DMemWData_o(DMemWData_o), .DMemWMask_o(DMemWMask_o), .csrWEnable_o(csrWEnable_o),
      .csrWAddr_o(csrWAddr_o), .csrWData_o(csrWData_o), .MW_PC_o(MW_PC_o),
      .MW_instr_o(MW_instr_o), .MW_nop_o(MW_nop_o), .MW_rdId_o(MW_rdId_o),
      .MW_wbData_o(MW_wbData_o), .MW_wbEnable_o(MW_wbEnable_o), .MW_misalign_o(MW_misalign_o)
   );

   // Bubble on the EM bank, write port ready
   task automatic em_clear();
      EM_nop_i = 1'b1; EM_isLoad_i = 1'b0; EM_isStore_i = 1'b0; EM_isCSR_i = 1'b0;
      EM_isAMO_i = 1'b0; EM_wbEnable_i = 1'b0; EM_rdId_i = 6'd0; EM_rs1Id_i = 6'd0;
      EM_csrId_i = 12'd0; EM_funct3_i = 3'd0; EM_funct7_i = 7'd0; EM_rs2_i = 32'd0;
      EM_Eresult_i = 32'd0; EM_addr_i = 32'd0; EM_Mdata_i = 32'd0; EM_CSRdata_i = 32'd0;
      EM_PC_i = 32'd0; EM_instr_i = NOP_INSTR; DMemWReady_i = 1'b1; W_flush_i = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk_i); #1;
   endtask

   task automatic drive_amo(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                            input logic [31:0] eres, input logic [31:0] mdata, input logic [5:0] rd);
      em_clear();
      EM_nop_i = 1'b0; EM_isAMO_i = 1'b1; EM_wbEnable_i = 1'b1; EM_funct3_i = 3'b010;
      EM_funct7_i = {op, 2'b00}; EM_addr_i = addr; EM_rs2_i = rs2; EM_Eresult_i = eres;
      EM_Mdata_i = mdata; EM_rdId_i = rd;
   endtask

   task automatic drive_sw(input logic [31:0] addr, input logic [31:0] data, input logic ready);
      em_clear();
      EM_nop_i = 1'b0; EM_isStore_i = 1'b1; EM_funct3_i = F3_SW; EM_addr_i = addr;
      EM_rs2_i = data; DMemWReady_i = ready; EM_PC_i = 32'h0000_0200; EM_instr_i = 32'h00B52023;
   endtask

   task automatic test_reset();
      em_clear();
      reset_i = 1'b0;
      repeat (2) next_cycle();
      @(negedge clk_i);
      checks++; if (MW_instr_o !== NOP_INSTR) $display("[TB] FAIL reset_instr: got %h expected %h", MW_instr_o, NOP_INSTR); else passes++;
      checks++; if (MW_nop_o !== 1'b1) $display("[TB] FAIL reset_nop: got %b expected 1", MW_nop_o); else passes++;
      checks++; if (MW_wbEnable_o !== 1'b0) $display("[TB] FAIL reset_wben: got %b expected 0", MW_wbEnable_o); else passes++;
      checks++; if (MW_misalign_o !== 1'b0) $display("[TB] FAIL reset_misalign: got %b expected 0", MW_misalign_o); else passes++;
      checks++; if (DMemWValid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", DMemWValid_o); else passes++;
      checks++; if (csrWEnable_o !== 1'b0) $display("[TB] FAIL reset_csr: got %b expected 0", csrWEnable_o); else passes++;
      checks++; if ({MW_PC_o, MW_wbData_o, MW_rdId_o} !== 70'd0) $display("[TB] FAIL reset_mw_zero: got %h/%h/%h expected 0", MW_PC_o, MW_wbData_o, MW_rdId_o); else passes++;
      next_cycle();
      reset_i = 1'b1;
      next_cycle();
   endtask

   task automatic test_store_byte();
      em_clear();
      EM_nop_i = 1'b0; EM_isStore_i = 1'b1; EM_funct3_i = F3_SB; EM_addr_i = 32'h0000_1003;
      EM_rs2_i = 32'h1234_56A5; EM_PC_i = 32'h0000_0100; EM_instr_i = 32'h00A581A3;
      @(negedge clk_i);
      checks++; if (DMemWValid_o !== 1'b1) $display("[TB] FAIL sb_valid: got %b expected 1", DMemWValid_o); else passes++;
      checks++; if (DMemWMask_o !== 4'b1000) $display("[TB] FAIL sb_mask: got %b expected 1000", DMemWMask_o); else passes++;
      checks++; if (DMemWData_o !== 32'hA5A5_A5A5) $display("[TB] FAIL sb_data: got %h expected a5a5a5a5", DMemWData_o); else passes++;
      checks++; if (DMemWAddr_o !== 32'h0000_1000) $display("[TB] FAIL sb_addr: got %h expected 00001000", DMemWAddr_o); else passes++;
      checks++; if (M_stall_o !== 1'b0) $display("[TB] FAIL sb_stall: got %b expected 0", M_stall_o); else passes++;
      next_cycle();
      checks++; if (MW_nop_o !== 1'b0 || MW_PC_o !== 32'h0000_0100) $display("[TB] FAIL sb_retire: got nop %b pc %h expected 0/00000100", MW_nop_o, MW_PC_o); else passes++;
      em_clear();
   endtask

   task automatic test_loads();
      logic [2:0]  f3  [6] = '{F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LH, F3_LW};
      logic [31:0] ad  [6] = '{32'h2002, 32'h2002, 32'h2002, 32'h2000, 32'h2000, 32'h2000};
      logic [31:0] exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_1280,
                               32'h0000_FF00, 32'hFFFF_FF00, 32'h1280_FF00};
      for (int i = 0; i < 6; i++) begin
         em_clear();
         EM_nop_i = 1'b0; EM_isLoad_i = 1'b1; EM_wbEnable_i = 1'b1; EM_rdId_i = 6'd5;
         EM_funct3_i = f3[i]; EM_addr_i = ad[i]; EM_Mdata_i = 32'h1280_FF00;
         @(negedge clk_i);
         checks++; if (DMemWValid_o !== 1'b0) $display("[TB] FAIL load%0d_valid: got %b expected 0", i, DMemWValid_o); else passes++;
         next_cycle();
         checks++; if (MW_wbData_o !== exp[i]) $display("[TB] FAIL load%0d_data: got %h expected %h", i, MW_wbData_o, exp[i]); else passes++;
         checks++; if (MW_wbEnable_o !== 1'b1 || MW_rdId_o !== 6'd5) $display("[TB] FAIL load%0d_wb: got en %b rd %0d expected 1/5", i, MW_wbEnable_o, MW_rdId_o); else passes++;
      end
      em_clear();
   endtask

   task automatic test_stall();
      int stall_cycles = 0;
      drive_sw(32'h0000_5004, 32'hDEAD_BEEF, 1'b0);
      EM_rdId_i = 6'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         if (M_stall_o === 1'b1) stall_cycles++;
         checks++; if (DMemWValid_o !== 1'b1 || DMemWAddr_o !== 32'h0000_5004 || DMemWData_o !== 32'hDEAD_BEEF || DMemWMask_o !== 4'hF)
            $display("[TB] FAIL stall%0d_port: got v%b %h %h %h expected v1 00005004 deadbeef f", i, DMemWValid_o, DMemWAddr_o, DMemWData_o, DMemWMask_o); else passes++;
         next_cycle();
         checks++; if (MW_nop_o !== 1'b1 || MW_wbEnable_o !== 1'b0) $display("[TB] FAIL stall%0d_bubble: got nop %b en %b expected 1/0", i, MW_nop_o, MW_wbEnable_o); else passes++;
      end
      DMemWReady_i = 1'b1;
      @(negedge clk_i);
      checks++; if (M_stall_o !== 1'b0 || DMemWValid_o !== 1'b1) $display("[TB] FAIL stall_accept: got stall %b valid %b expected 0/1", M_stall_o, DMemWValid_o); else passes++;
      checks++; if (stall_cycles != 3) $display("[TB] FAIL stall_count: got %0d expected 3", stall_cycles); else passes++;
      next_cycle();
      checks++; if (MW_nop_o !== 1'b0 || MW_instr_o !== 32'h00B52023 || MW_rdId_o !== 6'd3) $display("[TB] FAIL stall_retire: got nop %b instr %h rd %0d expected 0/00b52023/3", MW_nop_o, MW_instr_o, MW_rdId_o); else passes++;
      em_clear();
      next_cycle();
      checks++; if (MW_nop_o !== 1'b1) $display("[TB] FAIL stall_single_wb: got nop %b expected 1", MW_nop_o); else passes++;
   endtask

   task automatic test_lrsc();
      drive_amo(AMO_LR, 32'h4000, 32'd0, 32'd0, 32'h1111_1111, 6'd6);
      @(negedge clk_i);
      checks++; if (DMemWValid_o !== 1'b0) $display("[TB] FAIL lr_valid: got %b expected 0", DMemWValid_o); else passes++;
      next_cycle();
      checks++; if (MW_wbData_o !== 32'h1111_1111) $display("[TB] FAIL lr_data: got %h expected 11111111", MW_wbData_o); else passes++;
      drive_amo(AMO_SC, 32'h4000, 32'd7, 32'd0, 32'h1111_1111, 6'd6);
      @(negedge clk_i);
      checks++; if (DMemWValid_o !== 1'b1 || DMemWData_o !== 32'd7 || DMemWMask_o !== 4'hF || DMemWAddr_o !== 32'h4000)
         $display("[TB] FAIL sc1_write: got v%b %h %h %h expected v1 00000007 f 00004000", DMemWValid_o, DMemWData_o, DMemWMask_o, DMemWAddr_o); else passes++;
      next_cycle();
      checks++; if (MW_wbData_o !== 32'd0) $display("[TB] FAIL sc1_rd: got %h expected 0", MW_wbData_o); else passes++;
      drive_amo(AMO_SC, 32'h4000, 32'd7, 32'd0, 32'h1111_1111, 6'd6);
      @(negedge clk_i);
      checks++; if (DMemWValid_o !== 1'b0) $display("[TB] FAIL sc2_valid: got %b expected 0", DMemWValid_o); else passes++;
      next_cycle();
      checks++; if (MW_wbData_o !== 32'd1) $display("[TB] FAIL sc2_rd: got %h expected 1", MW_wbData_o); else passes++;
      em_clear();
   endtask

   task automatic test_lr_store_sc();
      drive_amo(AMO_LR, 32'h4000, 32'd0, 32'd0, 32'h0, 6'd6);
      next_cycle();
      drive_sw(32'h4000, 32'h55, 1'b1);
      next_cycle();
      drive_amo(AMO_SC, 32'h4000, 32'd9, 32'd0, 32'h0, 6'd6);
      @(negedge clk_i);
      checks++; if (DMemWValid_o !== 1'b0) $display("[TB] FAIL lrswsc_valid: got %b expected 0", DMemWValid_o); else passes++;
      next_cycle();
      checks++; if (MW_wbData_o !== 32'd1) $display("[TB] FAIL lrswsc_rd: got %h expected 1", MW_wbData_o); else passes++;
      em_clear();
   endtask

   task automatic test_amo_rmw();
      drive_amo(AMO_ADD, 32'h6000, 32'h5, 32'h55, 32'h10, 6'd8);
      @(negedge clk_i);
      checks++; if (DMemWValid_o !== 1'b1 || DMemWData_o !== 32'h55 || DMemWAddr_o !== 32'h6000) $display("[TB] FAIL amoadd_write: got v%b %h %h expected v1 00000055 00006000", DMemWValid_o, DMemWData_o, DMemWAddr_o); else passes++;
      next_cycle();
      checks++; if (MW_wbData_o !== 32'h10) $display("[TB] FAIL amoadd_rd: got %h expected 00000010", MW_wbData_o); else passes++;
      drive_amo(AMO_SWAP, 32'h6004, 32'h99, 32'h99, 32'h20, 6'd8);
      @(negedge clk_i);
      checks++; if (DMemWValid_o !== 1'b1 || DMemWData_o !== 32'h99) $display("[TB] FAIL amoswap_write: got v%b %h expected v1 00000099", DMemWValid_o, DMemWData_o); else passes++;
      next_cycle();
      checks++; if (MW_wbData_o !== 32'h20) $display("[TB] FAIL amoswap_rd: got %h expected 00000020", MW_wbData_o); else passes++;
      em_clear();
   endtask

   task automatic test_misalign();
      em_clear();
      EM_nop_i = 1'b0; EM_isLoad_i = 1'b1; EM_wbEnable_i = 1'b1; EM_funct3_i = F3_LW;
      EM_addr_i = 32'h3002; EM_rdId_i = 6'd4;
      @(negedge clk_i);
      checks++; if (DMemWValid_o !== 1'b0) $display("[TB] FAIL lw_mis_valid: got %b expected 0", DMemWValid_o); else passes++;
      next_cycle();
      checks++; if (MW_wbEnable_o !== 1'b0 || MW_misalign_o !== 1'b1) $display("[TB] FAIL lw_mis_flags: got en %b mis %b expected 0/1", MW_wbEnable_o, MW_misalign_o); else passes++;
      em_clear();
      EM_nop_i = 1'b0; EM_isStore_i = 1'b1; EM_funct3_i = F3_SH; EM_addr_i = 32'h3001;
      @(negedge clk_i);
      checks++; if (DMemWValid_o !== 1'b0) $display("[TB] FAIL sh_mis_valid: got %b expected 0", DMemWValid_o); else passes++;
      next_cycle();
      checks++; if (MW_misalign_o !== 1'b1) $display("[TB] FAIL sh_mis_flag: got %b expected 1", MW_misalign_o); else passes++;
      em_clear();
   endtask

   task automatic test_csr();
      em_clear();
      EM_nop_i = 1'b0; EM_isCSR_i = 1'b1; EM_wbEnable_i = 1'b1; EM_funct3_i = 3'b010;
      EM_rs1Id_i = 6'd0; EM_csrId_i = 12'h305; EM_CSRdata_i = 32'hCAFE_0001; EM_rdId_i = 6'd7;
      @(negedge clk_i);
      checks++; if (csrWEnable_o !== 1'b0) $display("[TB] FAIL csrrs_x0_strobe: got %b expected 0", csrWEnable_o); else passes++;
      next_cycle();
      checks++; if (MW_wbData_o !== 32'hCAFE_0001) $display("[TB] FAIL csrrs_rd: got %h expected cafe0001", MW_wbData_o); else passes++;
      em_clear();
      EM_nop_i = 1'b0; EM_isCSR_i = 1'b1; EM_funct3_i = 3'b001; EM_rs1Id_i = 6'd5;
      EM_csrId_i = 12'h300; EM_Eresult_i = 32'h1234;
      @(negedge clk_i);
      checks++; if (csrWEnable_o !== 1'b1 || csrWAddr_o !== 12'h300 || csrWData_o !== 32'h1234) $display("[TB] FAIL csrrw_strobe: got %b %h %h expected 1 300 00001234", csrWEnable_o, csrWAddr_o, csrWData_o); else passes++;
      next_cycle();
      em_clear();
   endtask

   task automatic test_flush();
      em_clear();
      EM_nop_i = 1'b0; EM_isLoad_i = 1'b1; EM_wbEnable_i = 1'b1; EM_funct3_i = F3_LW;
      EM_addr_i = 32'h2000; EM_rdId_i = 6'd9; W_flush_i = 1'b1;
      next_cycle();
      checks++; if (MW_nop_o !== 1'b1 || MW_wbEnable_o !== 1'b0) $display("[TB] FAIL flush_bubble: got nop %b en %b expected 1/0", MW_nop_o, MW_wbEnable_o); else passes++;
      em_clear();
   endtask

   task automatic test_reset_in_wait();
      drive_sw(32'h7000, 32'h1, 1'b0);
      @(negedge clk_i);
      checks++; if (M_stall_o !== 1'b1) $display("[TB] FAIL rstwait_stall: got %b expected 1", M_stall_o); else passes++;
      next_cycle();
      reset_i = 1'b0;
      em_clear();
      DMemWReady_i = 1'b0;
      @(negedge clk_i);
      checks++; if (DMemWValid_o !== 1'b0) $display("[TB] FAIL rstwait_valid_in_reset: got %b expected 0", DMemWValid_o); else passes++;
      next_cycle();
      reset_i = 1'b1;
      @(negedge clk_i);
      checks++; if (DMemWValid_o !== 1'b0 || M_stall_o !== 1'b0) $display("[TB] FAIL rstwait_idle: got valid %b stall %b expected 0/0", DMemWValid_o, M_stall_o); else passes++;
      next_cycle();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      em_clear();
      reset_i = 1'b0;
      test_reset();
      test_store_byte();
      test_loads();
      test_stall();
      test_lrsc();
      test_lr_store_sc();
      test_amo_rmw();
      test_misalign();
      test_csr();
      test_flush();
      test_reset_in_wait();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
